// File: rtl/mac_layer_sequencer.sv
// Layer sequencer for the shared 16x16 MAC: walks conv1, conv2 or FC windows one tap per cycle.
// It generates the memory addresses and writes one scaled, ReLU'd and saturated result per output.
module mac_layer_sequencer #(
    parameter int K      = 5,
    parameter int IMG1_W = 28,
    parameter int IMG2_W = 12,
    parameter int FC_LEN = 192,
    parameter int FC_OUT = 10,
    parameter int FRAC   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  layer,
    output logic [9:0]  a_addr,
    output logic [10:0] w_addr,
    output logic        mac_en,
    output logic        mac_clr,
    input  logic [31:0] mac_acc,
    output logic        out_we,
    output logic [9:0]  out_addr,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_WRITE, S_FIN} state_t;

    localparam int OW1 = IMG1_W - K + 1;
    localparam int OW2 = IMG2_W - K + 1;
    localparam logic [7:0] CONV_TAP_LAST = 8'(K * K - 1);
    localparam logic [7:0] FC_TAP_LAST   = 8'(FC_LEN - 1);
    localparam logic [2:0] KSIDE_LAST    = 3'(K - 1);
    localparam logic [9:0] OUT1_LAST     = 10'(OW1 * OW1 - 1);
    localparam logic [9:0] OUT2_LAST     = 10'(OW2 * OW2 - 1);
    localparam logic [9:0] FC_OUT_LAST   = 10'(FC_OUT - 1);

    state_t      state_q, state_d;
    logic [1:0]  layer_q, layer_d;
    logic [7:0]  tap_q, tap_d;
    logic [2:0]  kr_q, kr_d, kc_q, kc_d;
    logic [4:0]  r_q, r_d, c_q, c_d;
    logic [9:0]  out_cnt_q, out_cnt_d;

    logic [9:0]  a_addr_q, a_addr_d;
    logic [10:0] w_addr_q, w_addr_d;
    logic        mac_en_q, mac_en_d, mac_clr_q, mac_clr_d;
    logic        out_we_q, out_we_d;
    logic [9:0]  out_addr_q, out_addr_d;
    logic        busy_q, busy_d, done_q, done_d;

    logic        is_fc, last_tap, last_out, is_fc_d;
    logic [4:0]  out_w_last;
    logic [9:0]  img_w_d;
    logic [4:0]  row_sum, col_sum;
    logic signed [31:0] scaled;
    logic [15:0] sat_val;

    assign is_fc      = (layer_q == 2'd2);
    assign last_tap   = is_fc ? (tap_q == FC_TAP_LAST) : (tap_q == CONV_TAP_LAST);
    assign out_w_last = (layer_q == 2'd0) ? 5'(OW1 - 1) : 5'(OW2 - 1);
    assign last_out   = is_fc ? (out_cnt_q == FC_OUT_LAST)
                      : (layer_q == 2'd0) ? (out_cnt_q == OUT1_LAST) : (out_cnt_q == OUT2_LAST);

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        tap_d     = tap_q;
        kr_d      = kr_q;
        kc_d      = kc_q;
        r_d       = r_q;
        c_d       = c_q;
        out_cnt_d = out_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    layer_d = layer;
                    state_d = (layer == 2'd3) ? S_FIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_tap) begin
                    state_d = S_DRAIN;
                    tap_d   = 8'd0;
                    kr_d    = 3'd0;
                    kc_d    = 3'd0;
                end else begin
                    tap_d = tap_q + 8'd1;
                    if (!is_fc) begin
                        if (kc_q == KSIDE_LAST) begin
                            kc_d = 3'd0;
                            kr_d = kr_q + 3'd1;
                        end else begin
                            kc_d = kc_q + 3'd1;
                        end
                    end
                end
            end
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: begin
                if (out_ready) begin
                    if (last_out) begin
                        state_d   = S_FIN;
                        out_cnt_d = 10'd0;
                        r_d       = 5'd0;
                        c_d       = 5'd0;
                    end else begin
                        state_d   = S_ISSUE;
                        out_cnt_d = out_cnt_q + 10'd1;
                        if (!is_fc) begin
                            if (c_q == out_w_last) begin
                                c_d = 5'd0;
                                r_d = r_q + 5'd1;
                            end else begin
                                c_d = c_q + 5'd1;
                            end
                        end
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses are computed from the next-cycle counters so they lead mac_en by exactly one cycle,
    // matching the one-cycle memory read latency.
    always_comb begin
        is_fc_d  = (layer_d == 2'd2);
        img_w_d  = (layer_d == 2'd0) ? 10'(IMG1_W) : 10'(IMG2_W);
        row_sum  = r_d + {2'b00, kr_d};
        col_sum  = c_d + {2'b00, kc_d};
        a_addr_d = a_addr_q;
        w_addr_d = w_addr_q;
        if (state_d == S_ISSUE) begin
            if (is_fc_d) begin
                a_addr_d = {2'b00, tap_d};
                w_addr_d = 11'(out_cnt_d) * 11'(FC_LEN) + {3'b000, tap_d};
            end else begin
                a_addr_d = {5'd0, row_sum} * img_w_d + {5'd0, col_sum};
                w_addr_d = {8'd0, kr_d} * 11'(K) + {8'd0, kc_d};
            end
        end
        mac_en_d   = (state_q == S_ISSUE);
        mac_clr_d  = (state_q == S_ISSUE) && (tap_q == 8'd0);
        out_we_d   = (state_d == S_WRITE);
        out_addr_d = (state_d == S_WRITE) ? out_cnt_d : out_addr_q;
        busy_d     = (state_d == S_ISSUE) || (state_d == S_DRAIN) || (state_d == S_WRITE);
        done_d     = (state_d == S_FIN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            layer_q    <= 2'd0;
            tap_q      <= 8'd0;
            kr_q       <= 3'd0;
            kc_q       <= 3'd0;
            r_q        <= 5'd0;
            c_q        <= 5'd0;
            out_cnt_q  <= 10'd0;
            a_addr_q   <= 10'd0;
            w_addr_q   <= 11'd0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            out_we_q   <= 1'b0;
            out_addr_q <= 10'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            tap_q      <= tap_d;
            kr_q       <= kr_d;
            kc_q       <= kc_d;
            r_q        <= r_d;
            c_q        <= c_d;
            out_cnt_q  <= out_cnt_d;
            a_addr_q   <= a_addr_d;
            w_addr_q   <= w_addr_d;
            mac_en_q   <= mac_en_d;
            mac_clr_q  <= mac_clr_d;
            out_we_q   <= out_we_d;
            out_addr_q <= out_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // The accumulator is only final once WRITE is entered and the MAC stays idle until the
    // handshake, so the result is formed directly from mac_acc and stays stable during a stall.
    always_comb begin
        scaled = $signed(mac_acc) >>> FRAC;
        if (!is_fc && (scaled < 0))
            sat_val = 16'h0000;
        else if (scaled > 32'sd32767)
            sat_val = 16'h7FFF;
        else if (scaled < -32'sd32768)
            sat_val = 16'h8000;
        else
            sat_val = scaled[15:0];
    end

    assign a_addr   = a_addr_q;
    assign w_addr   = w_addr_q;
    assign mac_en   = mac_en_q;
    assign mac_clr  = mac_clr_q;
    assign out_we   = out_we_q;
    assign out_addr = out_addr_q;
    assign out_data = out_we_q ? sat_val : 16'h0000;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_mac_layer_sequencer.sv
// Directed bench for mac_layer_sequencer: models the memories and the MAC, then checks
// write counts, addresses, saturation, stalls, reset abort and done timing.
module tb_mac_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, out_ready;
    logic [1:0]  layer;
    logic [9:0]  a_addr, out_addr;
    logic [10:0] w_addr;
    logic        mac_en, mac_clr, out_we, busy, done;
    logic [31:0] mac_acc;
    logic [15:0] out_data;

    logic signed [15:0] a_val, w_val, a_data, w_data;
    logic signed [31:0] acc_m;
    logic               force_en;
    logic [31:0]        force_val;

    int checks_cnt = 0;
    int errors_cnt = 0;

    int   wr_cnt, first_addr, last_addr, done_edge;
    logic busy_seen;
    int   tap0_a, tap0_w, tap24_a, tap24_w;

    always #5 clk = ~clk;

    mac_layer_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .layer(layer),
        .a_addr(a_addr), .w_addr(w_addr), .mac_en(mac_en), .mac_clr(mac_clr),
        .mac_acc(mac_acc), .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    // Memories with one-cycle read latency (constant contents) feeding a 16x16 MAC.
    always @(posedge clk) begin
        a_data <= a_val;
        w_data <= w_val;
        if (mac_en)
            acc_m <= mac_clr ? (a_data * w_data) : (acc_m + a_data * w_data);
    end
    assign mac_acc = force_en ? force_val : acc_m;

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic run_layer(input logic [1:0] lyr, input int max_edges, input int stall_n,
                             input int dup_at, input logic chk_data,
                             input logic signed [15:0] exp_data, input int probe_out);
        int   edges, stall_done, tap_i, prev_a, prev_w;
        logic finished;
        logic [15:0] snap_d;
        logic [9:0]  snap_o, snap_a;
        edges = 0; stall_done = 0; tap_i = 0; prev_a = 0; prev_w = 0; finished = 1'b0;
        snap_d = '0; snap_o = '0; snap_a = '0;
        wr_cnt = 0; first_addr = -1; last_addr = -1; done_edge = -1; busy_seen = 1'b0;
        tap0_a = -1; tap0_w = -1; tap24_a = -1; tap24_w = -1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        layer = lyr;
        while (!finished && edges < max_edges) begin
            @(posedge clk);
            edges++;
            #1;
            start = (edges == dup_at);
            if (edges == dup_at) layer = 2'd3;
            if (busy) busy_seen = 1'b1;
            if (mac_en) begin
                tap_i = mac_clr ? 0 : tap_i + 1;
                if (wr_cnt == probe_out && tap_i == 0) begin tap0_a = prev_a; tap0_w = prev_w; end
                if (wr_cnt == probe_out && tap_i == 24) begin tap24_a = prev_a; tap24_w = prev_w; end
            end
            prev_a = int'(a_addr);
            prev_w = int'(w_addr);
            if (out_we && stall_done < stall_n) begin
                if (stall_done == 0) begin
                    snap_d = out_data; snap_o = out_addr; snap_a = a_addr;
                end else begin
                    check_val("stall_we", out_we, 1);
                    check_val("stall_data", out_data, snap_d);
                    check_val("stall_oaddr", out_addr, snap_o);
                    check_val("stall_aaddr", a_addr, snap_a);
                end
                check_val("stall_mac_en", mac_en, 0);
                out_ready = 1'b0;
                stall_done++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_we && out_ready) begin
                if (wr_cnt == 0) first_addr = int'(out_addr);
                last_addr = int'(out_addr);
                if (chk_data) check_val("wdata", $signed(out_data), exp_data);
                wr_cnt++;
            end
            if (done) begin
                done_edge = edges;
                finished = 1'b1;
            end
        end
        start = 1'b0;
        check_val("done_seen", finished, 1);
        $display("run layer=%0d writes=%0d first=%0d last=%0d done_edge=%0d",
                 lyr, wr_cnt, first_addr, last_addr, done_edge);
    endtask

    initial begin
        logic found;
        reset = 1'b0; start = 1'b0; layer = 2'd0; out_ready = 1'b1;
        a_val = 16'sd1; w_val = 16'sd256; force_en = 1'b0; force_val = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        check_val("init_busy", busy, 0);
        check_val("init_we", out_we, 0);
        check_val("init_mac_en", mac_en, 0);
        check_val("init_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // Abort conv1 while a write is pending
        @(negedge clk);
        start = 1'b1; layer = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (out_we) found = 1'b1;
        end
        check_val("rst_we_seen", found, 1);
        check_val("rst_busy_pre", busy, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_we", out_we, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_mac_en", mac_en, 0);
        check_val("rst_mac_clr", mac_clr, 0);
        check_val("rst_a_addr", a_addr, 0);
        check_val("rst_w_addr", w_addr, 0);
        check_val("rst_out_addr", out_addr, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_done", done, 0);
        reset = 1'b1;
        $display("reset abort done");

        // Full conv1: 25 taps of 1*256 -> 6400 >>> 8 = 25
        run_layer(2'd0, 16000, 0, 0, 1'b1, 16'sd25, -1);
        check_val("c1_writes", wr_cnt, 576);
        check_val("c1_first", first_addr, 0);
        check_val("c1_last", last_addr, 575);
        check_val("c1_done_edge", done_edge, 15553);
        check_val("c1_busy_seen", busy_seen, 1);

        // conv2, probe output (r=1,c=2)
        run_layer(2'd1, 2000, 0, 0, 1'b1, 16'sd25, 10);
        check_val("c2_writes", wr_cnt, 64);
        check_val("c2_last", last_addr, 63);
        check_val("c2_tap0_a", tap0_a, 14);
        check_val("c2_tap0_w", tap0_w, 0);
        check_val("c2_tap24_a", tap24_a, 66);
        check_val("c2_tap24_w", tap24_w, 24);
        check_val("c2_done_edge", done_edge, 1729);

        // FC: 192 * (-1*512) = -98304 >>> 8 = -384, sign kept
        a_val = -16'sd1; w_val = 16'sd512;
        run_layer(2'd2, 2500, 0, 0, 1'b1, -16'sd384, 9);
        check_val("fc_writes", wr_cnt, 10);
        check_val("fc_last", last_addr, 9);
        check_val("fc_tap0_a", tap0_a, 0);
        check_val("fc_tap0_w", tap0_w, 1728);
        check_val("fc_tap24_a", tap24_a, 24);
        check_val("fc_tap24_w", tap24_w, 1752);
        check_val("fc_done_edge", done_edge, 1941);

        // Saturation and ReLU with forced accumulator values
        force_en = 1'b1; force_val = 32'h7FFF_0000;
        run_layer(2'd2, 2500, 0, 0, 1'b1, 16'sh7FFF, -1);
        check_val("fc_sat_writes", wr_cnt, 10);
        run_layer(2'd1, 2000, 0, 0, 1'b1, 16'sh7FFF, -1);
        check_val("c2_sat_writes", wr_cnt, 64);
        force_val = 32'hFFFF_0000;
        run_layer(2'd1, 2000, 0, 0, 1'b1, 16'sd0, -1);
        check_val("c2_relu_writes", wr_cnt, 64);
        force_val = 32'h8000_0000;
        run_layer(2'd2, 2500, 0, 0, 1'b1, -16'sd32768, -1);
        check_val("fc_negsat_writes", wr_cnt, 10);
        force_en = 1'b0;

        // Stall the first write for 5 cycles
        a_val = 16'sd1; w_val = 16'sd256;
        run_layer(2'd1, 2000, 5, 0, 1'b1, 16'sd25, -1);
        check_val("stall_writes", wr_cnt, 64);
        check_val("stall_first", first_addr, 0);
        check_val("stall_done_edge", done_edge, 1734);

        // Invalid layer: immediate done, no writes, never busy
        run_layer(2'd3, 10, 0, 0, 1'b0, 16'sd0, -1);
        check_val("inv_writes", wr_cnt, 0);
        check_val("inv_done_edge", done_edge, 1);
        check_val("inv_busy", busy_seen, 0);

        // Start while busy is ignored
        run_layer(2'd1, 2000, 0, 100, 1'b1, 16'sd25, -1);
        check_val("dup_writes", wr_cnt, 64);
        check_val("dup_done_edge", done_edge, 1729);
        @(posedge clk);
        #1;
        check_val("dup_idle_busy", busy, 0);
        check_val("dup_idle_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
